// File: rtl/led_fill_monitor_pkg.sv
// Shared definitions for the LED fill-pattern monitor and its helpers.
//   - FSM state encodings (kept as plain localparams so legacy code can use them)
//   - therm_level(): thermometer-code decoder returning {legal, level}
package led_fill_monitor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Returns {legal, level}: legal=1 when value == (1<<k)-1 for some k in 0..width,
    // level=k. Level is 4 bits, so width is limited to 15.
    function automatic logic [4:0] therm_level(input logic [31:0] value,
                                               input int unsigned width);
        logic [4:0]  res;
        logic [32:0] pat;
        res = 5'd0;
        for (int unsigned k = 0; k <= 15; k++) begin
            pat = (33'd1 << k) - 33'd1;
            if ((k <= width) && ({1'b0, value} == pat)) begin
                res = {1'b1, 4'(k)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_hold_timer.sv
// Hold timer: counts consecutive enabled clocks and pulses expire_o on the clock where
// the count has already reached HOLD_MAX-1 and is enabled once more.
//   clk_i      system clock
//   reset_i    asynchronous active-high reset
//   clear_i    synchronous clear (wins over enable)
//   enable_i   advance the count this clock
//   expire_o   combinational pulse: enabled while count == HOLD_MAX-1
module led_hold_timer #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign expire_o = enable_i && !clear_i && (hold_q == HOLD_W'(HOLD_MAX - 1));

    always_comb begin
        hold_d = hold_q;
        if (clear_i) begin
            hold_d = '0;
        end else if (enable_i && (hold_q != HOLD_W'(HOLD_MAX))) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/led_fill_monitor.sv
// Receive-side checker for the thermometer "fill" LED generator.
// Samples the LED bus through a two-stage pipeline (s1 new, s2 previous), decodes the
// fill level, checks each change is the legal successor, counts completed frames and
// flags sequence / stall faults. All outputs are registered; led_in_i -> outputs is
// 2 clocks.
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   led_in_i       LED bus from the generator
//   level_o        decoded fill level (valid when level_valid_o)
//   level_valid_o  1 while tracking
//   frame_cnt_o    completed frames (WIDTH -> 0 wraps), saturating
//   err_seq_o      1-clock pulse on illegal value / transition
//   err_stall_o    1-clock pulse when value is stuck
//   fault_o        1 while in the fault state
module led_fill_monitor
    import led_fill_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] led_in_i,
    output logic [3:0]       level_o,
    output logic             level_valid_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             err_seq_o,
    output logic             err_stall_o,
    output logic             fault_o
);

    logic [WIDTH-1:0] s1_q, s2_q;
    // s1 holds a real sample (not the reset value); keeps IDLE from locking onto reset zeros.
    logic             s1_vld_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             err_seq_q, err_seq_d;
    logic             err_stall_q, err_stall_d;

    logic [4:0] therm;
    logic       s1_legal;
    logic [3:0] s1_level;
    logic [3:0] next_level;
    logic       changed;
    logic       stall_expire;

    assign therm      = therm_level(32'(s1_q), WIDTH);
    assign s1_legal   = therm[4];
    assign s1_level   = therm[3:0];
    assign changed    = (s1_q != s2_q);
    assign next_level = (level_q == 4'(WIDTH)) ? 4'd0 : level_q + 4'd1;

    // Counts only while tracking an unchanged value; any change or other state clears it.
    led_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  ((state_q != ST_TRACK) || changed),
        .enable_i ((state_q == ST_TRACK) && !changed),
        .expire_o (stall_expire)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_d     = frame_q;
        err_seq_d   = 1'b0;
        err_stall_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s1_vld_q && s1_legal) begin
                    state_d = ST_TRACK;
                    level_d = s1_level;
                end
            end
            ST_TRACK: begin
                if (!changed) begin
                    if (stall_expire) begin
                        err_stall_d = 1'b1;
                        state_d     = ST_FAULT;
                    end
                end else if (s1_legal && (s1_level == next_level)) begin
                    level_d = s1_level;
                    if ((level_q == 4'(WIDTH)) && (s1_level == 4'd0) && (frame_q != '1)) begin
                        frame_d = frame_q + CNT_W'(1);
                    end
                end else begin
                    err_seq_d = 1'b1;
                    state_d   = ST_FAULT;
                end
            end
            ST_FAULT: begin
                // Level keeps the last good value until the bus returns to empty.
                if (s1_q == '0) begin
                    state_d = ST_TRACK;
                    level_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s1_vld_q    <= 1'b0;
            state_q     <= ST_IDLE;
            level_q     <= 4'd0;
            frame_q     <= '0;
            err_seq_q   <= 1'b0;
            err_stall_q <= 1'b0;
        end else begin
            s1_q        <= led_in_i;
            s2_q        <= s1_q;
            s1_vld_q    <= 1'b1;
            state_q     <= state_d;
            level_q     <= level_d;
            frame_q     <= frame_d;
            err_seq_q   <= err_seq_d;
            err_stall_q <= err_stall_d;
        end
    end

    assign level_o       = level_q;
    assign level_valid_o = (state_q == ST_TRACK);
    assign fault_o       = (state_q == ST_FAULT);
    assign frame_cnt_o   = frame_q;
    assign err_seq_o     = err_seq_q;
    assign err_stall_o   = err_stall_q;

endmodule

// File: tb/tb_led_fill_monitor.sv
// Directed bench for led_fill_monitor. Two instances share the stimulus: the default
// build and a CNT_W=2 build used to observe frame counter saturation.
module tb_led_fill_monitor;

    logic       clk;
    logic       rst;
    logic [7:0] led;

    logic [3:0]  level, level2;
    logic        valid, valid2;
    logic [15:0] frames;
    logic [1:0]  frames2;
    logic        err_seq, err_seq2;
    logic        err_stall, err_stall2;
    logic        fault, fault2;

    int errors = 0;
    int checks = 0;
    int seq_cnt = 0;
    int stall_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0]  led;
        logic [3:0]  lvl;
        logic        vld;
        logic        flt;
        logic [15:0] frames;
        int          seq;
        int          stall;
    } vec_t;

    vec_t vecs[$];

    led_fill_monitor #(
        .WIDTH    (8),
        .HOLD_MAX (8),
        .CNT_W    (16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .led_in_i      (led),
        .level_o       (level),
        .level_valid_o (valid),
        .frame_cnt_o   (frames),
        .err_seq_o     (err_seq),
        .err_stall_o   (err_stall),
        .fault_o       (fault)
    );

    led_fill_monitor #(
        .WIDTH    (8),
        .HOLD_MAX (8),
        .CNT_W    (2)
    ) dut_sat (
        .clk_i         (clk),
        .reset_i       (rst),
        .led_in_i      (led),
        .level_o       (level2),
        .level_valid_o (valid2),
        .frame_cnt_o   (frames2),
        .err_seq_o     (err_seq2),
        .err_stall_o   (err_stall2),
        .fault_o       (fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (err_seq) seq_cnt++;
        if (err_stall) stall_cnt++;
        if (err_seq && err_stall) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] l, input logic [3:0] lv, input logic vd,
                                input logic fl, input logic [15:0] fr, input int sq,
                                input int st);
        vec_t v;
        v.led = l; v.lvl = lv; v.vld = vd; v.flt = fl; v.frames = fr; v.seq = sq; v.stall = st;
        return v;
    endfunction

    // Generator model: one value every 4 clocks; outputs settle 2 clocks after the change.
    task automatic apply_vec(input vec_t v, input string tag);
        int s0, t0;
        s0 = seq_cnt;
        t0 = stall_cnt;
        led = v.led;
        repeat (4) tick();
        chk({tag, " level"}, 32'(level), 32'(v.lvl));
        chk({tag, " valid"}, 32'(valid), 32'(v.vld));
        chk({tag, " fault"}, 32'(fault), 32'(v.flt));
        chk({tag, " frames"}, 32'(frames), 32'(v.frames));
        chk({tag, " seq_pulses"}, 32'(seq_cnt - s0), 32'(v.seq));
        chk({tag, " stall_pulses"}, 32'(stall_cnt - t0), 32'(v.stall));
    endtask

    initial begin
        int s0, t0;
        logic [7:0] fill [9];
        fill = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        // Three full frames: levels 1..8,0 repeated, frame count rises on each wrap.
        for (int i = 1; i <= 27; i++) begin
            vecs.push_back(mk(fill[i % 9], 4'(i % 9), 1'b1, 1'b0, 16'(i / 9), 0, 0));
        end
        // Skip 3 -> 5 faults with level held at 3; empty bus recovers.
        vecs.push_back(mk(8'h01, 4'd1, 1'b1, 1'b0, 16'd3, 0, 0));
        vecs.push_back(mk(8'h03, 4'd2, 1'b1, 1'b0, 16'd3, 0, 0));
        vecs.push_back(mk(8'h07, 4'd3, 1'b1, 1'b0, 16'd3, 0, 0));
        vecs.push_back(mk(8'h1F, 4'd3, 1'b0, 1'b1, 16'd3, 1, 0));
        vecs.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0, 16'd3, 0, 0));
        // Non-thermometer value while tracking.
        vecs.push_back(mk(8'h01, 4'd1, 1'b1, 1'b0, 16'd3, 0, 0));
        vecs.push_back(mk(8'h05, 4'd1, 1'b0, 1'b1, 16'd3, 1, 0));
        vecs.push_back(mk(8'h00, 4'd0, 1'b1, 1'b0, 16'd3, 0, 0));

        rst = 1'b1;
        led = 8'h00;
        #12;
        chk("reset level", 32'(level), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset frames", 32'(frames), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset err", 32'({err_seq, err_stall}), 32'd0);
        #8;
        rst = 1'b0;
        tick();
        chk("first sample valid", 32'(valid), 32'd0);
        tick();
        chk("track valid", 32'(valid), 32'd1);
        chk("track level", 32'(level), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 26) chk("sat build frames after 3", 32'(frames2), 32'd3);
        end

        // Stall: a value stuck for 8 compares faults on the 10th clock after it is driven.
        apply_vec(mk(8'h01, 4'd1, 1'b1, 1'b0, 16'd3, 0, 0), "stall pre");
        s0 = seq_cnt;
        t0 = stall_cnt;
        led = 8'h03;
        repeat (9) tick();
        chk("stall not early", 32'(err_stall), 32'd0);
        tick();
        chk("stall pulse", 32'(err_stall), 32'd1);
        chk("stall fault", 32'(fault), 32'd1);
        chk("stall level", 32'(level), 32'd2);
        repeat (5) tick();
        chk("stall once", 32'(stall_cnt - t0), 32'd1);
        chk("stall no seq", 32'(seq_cnt - s0), 32'd0);
        apply_vec(mk(8'h00, 4'd0, 1'b1, 1'b0, 16'd3, 0, 0), "stall recover");
        // One clock shorter: stepping away in time raises nothing.
        apply_vec(mk(8'h01, 4'd1, 1'b1, 1'b0, 16'd3, 0, 0), "hold7 pre");
        led = 8'h03;
        repeat (8) tick();
        apply_vec(mk(8'h07, 4'd3, 1'b1, 1'b0, 16'd3, 0, 0), "hold7 step");

        // Fourth wrap: 16-bit counter reaches 4, 2-bit counter stays saturated.
        for (int k = 4; k <= 9; k++) begin
            apply_vec(mk(fill[k % 9], 4'(k % 9), 1'b1, 1'b0, (k == 9) ? 16'd4 : 16'd3, 0, 0),
                      $sformatf("wrap4 k%0d", k));
        end
        chk("sat build frames", 32'(frames2), 32'd3);
        chk("sat build no fault", 32'(fault2), 32'd0);

        // Illegal value straight out of reset: IDLE ignores it.
        rst = 1'b1;
        led = 8'h05;
        tick();
        tick();
        rst = 1'b0;
        s0 = seq_cnt;
        repeat (6) tick();
        chk("idle illegal valid", 32'(valid), 32'd0);
        chk("idle illegal fault", 32'(fault), 32'd0);
        chk("idle illegal seq", 32'(seq_cnt - s0), 32'd0);
        chk("idle frames cleared", 32'(frames), 32'd0);

        // Async reset mid-frame at level 5, then resume at 0x3F.
        for (int k = 0; k <= 5; k++) begin
            apply_vec(mk(fill[k], 4'(k), 1'b1, 1'b0, 16'd0, 0, 0), $sformatf("climb k%0d", k));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async level", 32'(level), 32'd0);
        chk("async valid", 32'(valid), 32'd0);
        chk("async fault", 32'(fault), 32'd0);
        led = 8'h3F;
        tick();
        rst = 1'b0;
        tick();
        chk("resume not yet", 32'(valid), 32'd0);
        tick();
        chk("resume valid", 32'(valid), 32'd1);
        chk("resume level", 32'(level), 32'd6);
        apply_vec(mk(8'h7F, 4'd7, 1'b1, 1'b0, 16'd0, 0, 0), "resume 7");
        apply_vec(mk(8'hFF, 4'd8, 1'b1, 1'b0, 16'd0, 0, 0), "resume 8");
        apply_vec(mk(8'h00, 4'd0, 1'b1, 1'b0, 16'd1, 0, 0), "resume wrap");

        chk("seq and stall exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
